weather_sensor_hub: RTL

Parametrised successor to the single-cycle weather transceiver. It holds NUM_CH sensor channels (temperature, humidity, wind, ...), each DATA_W bits wide. Channels are updated through a valid/ready command port with add, subtract and load operations, and commands are accepted only inside a configurable hour window. On request, the block streams a snapshot report (header plus one word per channel) over a valid/ready TX port towards the radio link layer.

---
 rtl/weather_pkg.sv | 23 ++
 rtl/sat_alu.sv | 32 +++
 rtl/weather_sensor_hub.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/weather_pkg.sv
// Purpose  : shared op encodings, report FSM states and default hour window for the sensor hub.
// Latency  : n/a (type and constant definitions only).
// Backpres.: n/a.
package weather_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_LOAD = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SNAP = 2'b01,
        HDR  = 2'b10,
        DATA = 2'b11
    } state_t;

    localparam int DEF_WIN_START = 12;
    localparam int DEF_WIN_END   = 16;

endpackage

// File: rtl/sat_alu.sv
// Purpose  : clamped add/sub/load on one channel value; ports i_op/i_a/i_b in, o_y out.
// Latency  : combinational.
// Backpres.: none.
module sat_alu
    import weather_pkg::*;
#(
    parameter int DATA_W = 6
) (
    input  logic [1:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_y
);

    // One extra bit catches carry-out (add) and borrow (sub).
    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_dif;

    assign w_sum = {1'b0, i_a} + {1'b0, i_b};
    assign w_dif = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        o_y = i_a;
        case (i_op)
            OP_ADD:  o_y = w_sum[DATA_W] ? {DATA_W{1'b1}} : w_sum[DATA_W-1:0];
            OP_SUB:  o_y = w_dif[DATA_W] ? {DATA_W{1'b0}} : w_dif[DATA_W-1:0];
            OP_LOAD: o_y = i_b;
            default: o_y = i_a;
        endcase
    end

endmodule

// File: rtl/weather_sensor_hub.sv
// Purpose  : NUM_CH sensor channels updated by windowed commands; streams header+snapshot frames.
//            Ports: clk/rst, cur_hour, cmd_* (valid/ready), rpt_req, tx_* (valid/ready), ch_value,
//            enable_transceiver, err_cnt.
// Latency  : command applied 2 edges after acceptance is presented; header valid 2 edges after rpt_req.
// Backpres.: cmd_ready low outside the hour window or while a report is in flight; tx words held while !tx_ready.
module weather_sensor_hub
    import weather_pkg::*;
#(
    parameter int                         NUM_CH    = 3,
    parameter int                         DATA_W    = 6,
    parameter int                         HOUR_W    = 5,
    parameter int                         WIN_START = DEF_WIN_START,
    parameter int                         WIN_END   = DEF_WIN_END,
    parameter logic [NUM_CH*DATA_W-1:0]   RST_VAL   = {6'd19, 6'd52, 6'd43},
    localparam int                        CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [HOUR_W-1:0]          cur_hour,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [CH_W-1:0]            cmd_ch,
    input  logic [DATA_W-1:0]          cmd_data,
    input  logic                       rpt_req,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic [DATA_W-1:0]          tx_data,
    output logic                       tx_last,
    output logic [NUM_CH*DATA_W-1:0]   ch_value,
    output logic                       enable_transceiver,
    output logic [7:0]                 err_cnt
);

    logic                     r_en;
    state_t                   r_state;
    logic                     r_stg_vld;
    logic [1:0]               r_stg_op;
    logic [CH_W-1:0]          r_stg_ch;
    logic [DATA_W-1:0]        r_stg_dat;
    logic [NUM_CH*DATA_W-1:0] r_ch;
    logic [NUM_CH*DATA_W-1:0] r_snap;
    logic [7:0]               r_err;
    logic [DATA_W-1:0]        r_seq;
    logic [DATA_W-1:0]        r_tx_dat;
    logic                     r_tx_vld;
    logic                     r_tx_last;
    logic [CH_W-1:0]          r_idx;

    logic                     w_in_win;
    logic                     w_cmd_acc;
    logic                     w_stg_hit;
    logic [DATA_W-1:0]        w_alu_a;
    logic [DATA_W-1:0]        w_alu_y;
    logic [NUM_CH*DATA_W-1:0] w_ch_nxt;
    logic [CH_W-1:0]          w_nxt_idx;

    assign w_in_win  = (int'(cur_hour) >= WIN_START) && (int'(cur_hour) <= WIN_END);
    assign cmd_ready = r_en && (r_state == IDLE);
    assign w_cmd_acc = cmd_valid && cmd_ready;
    assign w_nxt_idx = r_idx + 1'b1;

    // Select the staged target channel; an out-of-range index leaves w_stg_hit low.
    always_comb begin
        w_alu_a   = '0;
        w_stg_hit = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_stg_ch == CH_W'(i)) begin
                w_alu_a   = r_ch[i*DATA_W +: DATA_W];
                w_stg_hit = 1'b1;
            end
        end
    end

    sat_alu #(
        .DATA_W (DATA_W)
    ) u_sat_alu (
        .i_op (r_stg_op),
        .i_a  (w_alu_a),
        .i_b  (r_stg_dat),
        .o_y  (w_alu_y)
    );

    // Channel values after this edge's stage apply; the snapshot reads this so a
    // command accepted alongside rpt_req lands in the report.
    always_comb begin
        w_ch_nxt = r_ch;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_stg_vld && (r_stg_ch == CH_W'(i))) begin
                w_ch_nxt[i*DATA_W +: DATA_W] = w_alu_y;
            end
        end
    end

    // Window flag, command stage, channel storage and error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en      <= 1'b0;
            r_stg_vld <= 1'b0;
            r_stg_op  <= '0;
            r_stg_ch  <= '0;
            r_stg_dat <= '0;
            r_ch      <= RST_VAL;
            r_err     <= '0;
        end else begin
            r_en      <= w_in_win;
            r_ch      <= w_ch_nxt;
            r_stg_vld <= w_cmd_acc;
            if (w_cmd_acc) begin
                r_stg_op  <= cmd_op;
                r_stg_ch  <= cmd_ch;
                r_stg_dat <= cmd_data;
            end
            if (r_stg_vld && !w_stg_hit && (r_err != 8'hFF)) begin
                r_err <= r_err + 8'd1;
            end
        end
    end

    // Report FSM with registered TX outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_snap    <= '0;
            r_seq     <= '0;
            r_idx     <= '0;
            r_tx_vld  <= 1'b0;
            r_tx_dat  <= '0;
            r_tx_last <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (rpt_req) begin
                        r_state <= SNAP;
                    end
                end
                SNAP: begin
                    r_snap    <= w_ch_nxt;
                    r_tx_vld  <= 1'b1;
                    r_tx_dat  <= r_seq;
                    r_tx_last <= 1'b0;
                    r_state   <= HDR;
                end
                HDR: begin
                    if (tx_ready) begin
                        r_state   <= DATA;
                        r_idx     <= '0;
                        r_tx_dat  <= r_snap[DATA_W-1:0];
                        r_tx_last <= (NUM_CH == 1);
                    end
                end
                DATA: begin
                    if (tx_ready) begin
                        if (r_idx == CH_W'(NUM_CH - 1)) begin
                            r_state   <= IDLE;
                            r_tx_vld  <= 1'b0;
                            r_tx_last <= 1'b0;
                            r_tx_dat  <= '0;
                            r_seq     <= r_seq + 1'b1;
                        end else begin
                            r_idx     <= w_nxt_idx;
                            r_tx_dat  <= r_snap[int'(w_nxt_idx)*DATA_W +: DATA_W];
                            r_tx_last <= (w_nxt_idx == CH_W'(NUM_CH - 1));
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tx_valid           = r_tx_vld;
    assign tx_data            = r_tx_dat;
    assign tx_last            = r_tx_last;
    assign ch_value           = r_ch;
    assign enable_transceiver = r_en;
    assign err_cnt            = r_err;

endmodule
